// File: rtl/instr_decode_seq.sv
// Instruction register, decoder and Q1-Q4 cycle sequencer feeding alu.
// Build option: define DECODER_SLEEP_EN to add the SLEEP park state and the wake input.
module instr_decode_seq #(
    parameter int RESET_FLUSH = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [13:0] rom_data,
    input  logic        skip_req,
`ifdef DECODER_SLEEP_EN
    input  logic        wake,
`endif
    output logic        fetch,
    output logic [1:0]  phase,
    output logic [4:0]  opcode,
    output logic [9:0]  operand,
    output logic        alu_en,
    output logic        sfr_rd,
    output logic        sfr_wr,
    output logic        flush,
    output logic        illegal
);

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    phase_t      state_q, state_d;
    logic        load;
    logic        flush_q, flush_d;
    logic        rd_q, wr_q, branch_q, illegal_q;
    logic [4:0]  opcode_q;
    logic [9:0]  operand_q;

    logic [4:0]  dec_opcode;
    logic [9:0]  dec_operand;
    logic        dec_illegal, dec_rd, dec_wr, dec_branch;
`ifdef DECODER_SLEEP_EN
    logic        dec_sleep;
    logic        park_q, park_d, sleep_q;
`endif

    // Decode of the word being fetched; registered into the IR fields at the Q4 edge.
    always_comb begin
        dec_opcode  = 5'd0;
        dec_operand = {2'b00, rom_data[7:0]};
        dec_illegal = 1'b0;
        dec_rd      = 1'b0;
        dec_wr      = 1'b0;
        dec_branch  = 1'b0;
`ifdef DECODER_SLEEP_EN
        dec_sleep   = 1'b0;
`endif
        case (rom_data[13:12])
            2'b00: begin
                dec_rd = 1'b1;
                dec_wr = rom_data[7];
                case (rom_data[11:8])
                    4'h0: begin
                        if (rom_data[7]) begin
                            dec_opcode = 5'd30;
                        end else begin
                            dec_rd = 1'b0;
                            if (rom_data[4:0] == 5'd0) begin
                                dec_opcode = 5'd0;
                            end else if (rom_data[6:0] == 7'h08 || rom_data[6:0] == 7'h09) begin
                                dec_opcode = 5'd3;
                                dec_branch = 1'b1;
                            end else if (rom_data[6:0] == 7'h63) begin
                                dec_opcode = 5'd0;
`ifdef DECODER_SLEEP_EN
                                dec_sleep  = 1'b1;
`endif
                            end else if (rom_data[6:0] == 7'h64) begin
                                dec_opcode = 5'd0;
                            end else begin
                                dec_illegal = 1'b1;
                                dec_operand = 10'd0;
                            end
                        end
                    end
                    4'h1: begin
                        dec_opcode = rom_data[7] ? 5'd31 : 5'd29;
                        dec_rd     = rom_data[7];
                    end
                    // SUBWF..INCFSZ occupy consecutive alu codes 11..24 in nibble order.
                    default: dec_opcode = 5'd9 + {1'b0, rom_data[11:8]};
                endcase
            end
            2'b01: begin
                dec_operand = rom_data[9:0];
                dec_rd      = 1'b1;
                dec_wr      = !rom_data[11];
                case (rom_data[11:10])
                    2'b00:   dec_opcode = 5'd4;
                    2'b01:   dec_opcode = 5'd5;
                    2'b10:   dec_opcode = 5'd6;
                    default: dec_opcode = 5'd28;
                endcase
            end
            2'b10: begin
                dec_operand = rom_data[9:0];
                dec_opcode  = rom_data[11] ? 5'd1 : 5'd2;
                dec_branch  = 1'b1;
            end
            default: begin
                casez (rom_data[11:8])
                    4'b00??: dec_opcode = 5'd7;
                    4'b01??: begin
                        dec_opcode = 5'd8;
                        dec_branch = 1'b1;
                    end
                    4'b110?: dec_opcode = 5'd9;
                    4'b111?: dec_opcode = 5'd10;
                    4'b1000: dec_opcode = 5'd25;
                    4'b1001: dec_opcode = 5'd26;
                    4'b1010: dec_opcode = 5'd27;
                    default: begin
                        dec_illegal = 1'b1;
                        dec_operand = 10'd0;
                    end
                endcase
            end
        endcase
    end

    // Sequencer next state and phase-gated strobes; stall freezes everything and drops strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        flush_d = !flush_q && (branch_q || skip_req);
`ifdef DECODER_SLEEP_EN
        park_d  = park_q;
`endif
        if (!stall) begin
`ifdef DECODER_SLEEP_EN
            if (park_q) begin
                if (wake) begin
                    state_d = Q2;
                    park_d  = 1'b0;
                end
            end else
`endif
            begin
                case (state_q)
                    Q1: state_d = Q2;
                    Q2: state_d = Q3;
                    Q3: state_d = Q4;
                    default: begin
                        state_d = Q1;
                        load    = 1'b1;
`ifdef DECODER_SLEEP_EN
                        park_d  = sleep_q;
`endif
                    end
                endcase
            end
        end

        phase   = state_q;
        opcode  = opcode_q;
        operand = operand_q;
        flush   = flush_q;
        illegal = illegal_q;
        fetch   = (state_q == Q4) && !stall;
        alu_en  = (state_q == Q3) && !stall && !flush_q;
        sfr_rd  = (state_q == Q2) && !stall && rd_q;
        sfr_wr  = (state_q == Q4) && !stall && wr_q;
    end

    // IR fields are stored already masked by the flush decision, so a flushed cycle is inert.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= Q1;
            flush_q   <= (RESET_FLUSH != 0);
            opcode_q  <= 5'd0;
            operand_q <= 10'd0;
            illegal_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            branch_q  <= 1'b0;
`ifdef DECODER_SLEEP_EN
            park_q    <= 1'b0;
            sleep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef DECODER_SLEEP_EN
            park_q  <= park_d;
`endif
            if (load) begin
                flush_q   <= flush_d;
                opcode_q  <= flush_d ? 5'd0 : dec_opcode;
                operand_q <= flush_d ? 10'd0 : dec_operand;
                illegal_q <= !flush_d && dec_illegal;
                rd_q      <= !flush_d && dec_rd;
                wr_q      <= !flush_d && dec_wr;
                branch_q  <= !flush_d && dec_branch;
`ifdef DECODER_SLEEP_EN
                sleep_q   <= !flush_d && dec_sleep;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_seq.sv
// Bench for instr_decode_seq: directed steps then random traffic against a
// mnemonic-table reference model of the instruction cycle.
module tb_instr_decode_seq;

    localparam int RF = 1;
`ifdef DECODER_SLEEP_EN
    localparam bit SLEEP_EN = 1'b1;
`else
    localparam bit SLEEP_EN = 1'b0;
`endif

    localparam int F_LIT  = 0;
    localparam int F_BYTE = 1;
    localparam int F_RAW  = 2;
    localparam int W_NO   = 0;
    localparam int W_D    = 1;
    localparam int W_YES  = 2;

    logic        clock = 1'b0;
    logic        reset, stall, skip_req, wake;
    logic [13:0] rom_data;
    logic        fetch, alu_en, sfr_rd, sfr_wr, flush, illegal;
    logic [1:0]  phase;
    logic [4:0]  opcode;
    logic [9:0]  operand;

    int assertions = 0;
    int failures   = 0;
    int alu_seen   = 0;

    always #5 clock = ~clock;

    instr_decode_seq #(.RESET_FLUSH(RF)) dut (
        .clock    (clock),
        .reset    (reset),
        .stall    (stall),
        .rom_data (rom_data),
        .skip_req (skip_req),
`ifdef DECODER_SLEEP_EN
        .wake     (wake),
`endif
        .fetch    (fetch),
        .phase    (phase),
        .opcode   (opcode),
        .operand  (operand),
        .alu_en   (alu_en),
        .sfr_rd   (sfr_rd),
        .sfr_wr   (sfr_wr),
        .flush    (flush),
        .illegal  (illegal)
    );

    typedef struct {
        logic [13:0] mask;
        logic [13:0] value;
        int          code;
        int          fmt;
        bit          rd;
        int          wr;
        bit          br;
    } entry_t;

    entry_t tbl[$];

    // Reference model state: executing word, its phase, whether it is flushed, SLEEP park.
    int          m_phase;
    bit          m_flush;
    bit          m_parked;
    logic [13:0] m_ir;

    function automatic void add(input logic [13:0] m, input logic [13:0] v, input int c,
                                input int f, input bit r, input int w, input bit b);
        entry_t e;
        e.mask = m; e.value = v; e.code = c; e.fmt = f; e.rd = r; e.wr = w; e.br = b;
        tbl.push_back(e);
    endfunction

    function automatic void build_table();
        add(14'h3F80, 14'h0080, 30, F_BYTE, 1, W_YES, 0); // MOVWF
        add(14'h3F9F, 14'h0000,  0, F_RAW,  0, W_NO,  0); // NOP
        add(14'h3FFF, 14'h0008,  3, F_RAW,  0, W_NO,  1); // RETURN
        add(14'h3FFF, 14'h0009,  3, F_RAW,  0, W_NO,  1); // RETFIE
        add(14'h3FFF, 14'h0063,  0, F_RAW,  0, W_NO,  0); // SLEEP
        add(14'h3FFF, 14'h0064,  0, F_RAW,  0, W_NO,  0); // CLRWDT
        add(14'h3F80, 14'h0100, 29, F_BYTE, 0, W_NO,  0); // CLRW
        add(14'h3F80, 14'h0180, 31, F_BYTE, 1, W_YES, 0); // CLRF
        add(14'h3F00, 14'h0200, 11, F_BYTE, 1, W_D,   0); // SUBWF
        add(14'h3F00, 14'h0300, 12, F_BYTE, 1, W_D,   0); // DECF
        add(14'h3F00, 14'h0400, 13, F_BYTE, 1, W_D,   0); // IORWF
        add(14'h3F00, 14'h0500, 14, F_BYTE, 1, W_D,   0); // ANDWF
        add(14'h3F00, 14'h0600, 15, F_BYTE, 1, W_D,   0); // XORWF
        add(14'h3F00, 14'h0700, 16, F_BYTE, 1, W_D,   0); // ADDWF
        add(14'h3F00, 14'h0800, 17, F_BYTE, 1, W_D,   0); // MOVF
        add(14'h3F00, 14'h0900, 18, F_BYTE, 1, W_D,   0); // COMF
        add(14'h3F00, 14'h0A00, 19, F_BYTE, 1, W_D,   0); // INCF
        add(14'h3F00, 14'h0B00, 20, F_BYTE, 1, W_D,   0); // DECFSZ
        add(14'h3F00, 14'h0C00, 21, F_BYTE, 1, W_D,   0); // RRF
        add(14'h3F00, 14'h0D00, 22, F_BYTE, 1, W_D,   0); // RLF
        add(14'h3F00, 14'h0E00, 23, F_BYTE, 1, W_D,   0); // SWAPF
        add(14'h3F00, 14'h0F00, 24, F_BYTE, 1, W_D,   0); // INCFSZ
        add(14'h3C00, 14'h1000,  4, F_RAW,  1, W_YES, 0); // BCF
        add(14'h3C00, 14'h1400,  5, F_RAW,  1, W_YES, 0); // BSF
        add(14'h3C00, 14'h1800,  6, F_RAW,  1, W_NO,  0); // BTFSC
        add(14'h3C00, 14'h1C00, 28, F_RAW,  1, W_NO,  0); // BTFSS
        add(14'h3800, 14'h2000,  2, F_RAW,  0, W_NO,  1); // CALL
        add(14'h3800, 14'h2800,  1, F_RAW,  0, W_NO,  1); // GOTO
        add(14'h3C00, 14'h3000,  7, F_LIT,  0, W_NO,  0); // MOVLW
        add(14'h3C00, 14'h3400,  8, F_LIT,  0, W_NO,  1); // RETLW
        add(14'h3E00, 14'h3C00,  9, F_LIT,  0, W_NO,  0); // SUBLW
        add(14'h3E00, 14'h3E00, 10, F_LIT,  0, W_NO,  0); // ADDLW
        add(14'h3F00, 14'h3800, 25, F_LIT,  0, W_NO,  0); // IORLW
        add(14'h3F00, 14'h3900, 26, F_LIT,  0, W_NO,  0); // ANDLW
        add(14'h3F00, 14'h3A00, 27, F_LIT,  0, W_NO,  0); // XORLW
    endfunction

    function automatic void ref_decode(input logic [13:0] w, output int code, output logic [9:0] opd,
                                       output bit ill, output bit rd, output bit wr, output bit br);
        bit found = 1'b0;
        code = 0; opd = 10'd0; ill = 1'b1; rd = 1'b0; wr = 1'b0; br = 1'b0;
        foreach (tbl[i]) begin
            if (!found && ((w & tbl[i].mask) == tbl[i].value)) begin
                found = 1'b1;
                ill   = 1'b0;
                code  = tbl[i].code;
                rd    = tbl[i].rd;
                br    = tbl[i].br;
                wr    = (tbl[i].wr == W_YES) || (tbl[i].wr == W_D && w[7]);
                case (tbl[i].fmt)
                    F_LIT:   opd = {2'b00, w[7:0]};
                    F_BYTE:  opd = {2'b00, w[7], w[6:0]};
                    default: opd = w[9:0];
                endcase
            end
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int         code;
        logic [9:0] opd;
        bit         ill, rd, wr, br;
        ref_decode(m_ir, code, opd, ill, rd, wr, br);
        if (alu_en === 1'b1) alu_seen++;
        check("phase",   16'(phase),   16'(m_phase));
        check("flush",   16'(flush),   16'(m_flush));
        check("opcode",  16'(opcode),  m_flush ? 16'd0 : 16'(code));
        check("operand", 16'(operand), m_flush ? 16'd0 : 16'(opd));
        check("illegal", 16'(illegal), 16'(!m_flush && ill));
        check("fetch",   16'(fetch),   16'(m_phase == 3 && !stall));
        check("alu_en",  16'(alu_en),  16'(m_phase == 2 && !stall && !m_flush));
        check("sfr_rd",  16'(sfr_rd),  16'(m_phase == 1 && !stall && !m_flush && rd));
        check("sfr_wr",  16'(sfr_wr),  16'(m_phase == 3 && !stall && !m_flush && wr));
    endtask

    task automatic modelAdvance();
        int         code;
        logic [9:0] opd;
        bit         ill, rd, wr, br;
        if (stall) return;
        if (m_parked) begin
            if (wake) begin
                m_parked = 1'b0;
                m_phase  = 1;
            end
        end else if (m_phase == 3) begin
            ref_decode(m_ir, code, opd, ill, rd, wr, br);
            m_parked = SLEEP_EN && !m_flush && (m_ir == 14'h0063);
            m_flush  = !m_flush && (br || skip_req);
            m_ir     = rom_data;
            m_phase  = 0;
        end else begin
            m_phase++;
        end
    endtask

    // Called at a negedge; leaves the bench at the next negedge.
    task automatic applyStimulus(input bit st, input logic [13:0] word, input bit sk, input bit wk);
        stall    = st;
        rom_data = word;
        skip_req = sk;
        wake     = wk;
        #1;
        checkOutput();
        @(posedge clock);
        modelAdvance();
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        m_phase  = 0;
        m_flush  = (RF != 0);
        m_parked = 1'b0;
        m_ir     = 14'h0000;
        checkOutput();
        @(posedge clock);
        @(negedge clock);
        checkOutput();
        reset = 1'b0;
    endtask

    task automatic steps(input int n, input logic [13:0] word);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, word, 1'b0, 1'b0);
    endtask

    initial begin
        build_table();
        stall = 1'b0; skip_req = 1'b0; wake = 1'b0; rom_data = 14'h3055; reset = 1'b0;

        $display("[TB] reset and MOVLW");
        doReset();
        check("rst_flush", 16'(flush), 16'(RF));
        check("rst_phase", 16'(phase), 16'd0);
        check("rst_opcode", 16'(opcode), 16'd0);
        steps(4, 14'h3055);
        check("movlw_opcode",  16'(opcode),  16'd7);
        check("movlw_operand", 16'(operand), 16'h055);
        steps(4, 14'h07A3);

        $display("[TB] ADDWF and reset during Q4");
        check("addwf_opcode",  16'(opcode),  16'd16);
        check("addwf_operand", 16'(operand), 16'h0A3);
        steps(3, 14'h0000);
        check("addwf_sfr_wr", 16'(sfr_wr), 16'd1);
        doReset();
        check("midrst_sfr_wr", 16'(sfr_wr), 16'd0);
        check("midrst_phase",  16'(phase),  16'd0);

        $display("[TB] GOTO flush");
        steps(4, 14'h2812);
        check("goto_opcode",  16'(opcode),  16'd1);
        check("goto_operand", 16'(operand), 16'h012);
        steps(4, 14'h3055);
        check("goto_flush", 16'(flush), 16'd1);
        check("goto_flush_opcode", 16'(opcode), 16'd0);
        steps(2, 14'h3055);
        check("goto_flush_alu_en", 16'(alu_en), 16'd0);
        steps(1, 14'h3055);
        check("goto_flush_fetch", 16'(fetch), 16'd1);
        steps(1, 14'h0B8C);

        $display("[TB] DECFSZ skip");
        check("decfsz_opcode", 16'(opcode), 16'd20);
        steps(3, 14'h0000);
        applyStimulus(1'b0, 14'h3055, 1'b1, 1'b0);
        check("skip_flush", 16'(flush), 16'd1);
        steps(3, 14'h0000);
        applyStimulus(1'b0, 14'h3055, 1'b1, 1'b0);
        check("skip_no_double", 16'(flush), 16'd0);
        check("skip_next_opcode", 16'(opcode), 16'd7);

        $display("[TB] stall in Q3");
        steps(2, 14'h0000);
        alu_seen = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 14'h0000, 1'b0, 1'b0);
        check("stall_phase", 16'(phase), 16'd2);
        applyStimulus(1'b0, 14'h0000, 1'b0, 1'b0);
        check("stall_alu_once", 16'(alu_seen), 16'd1);
        check("stall_release_phase", 16'(phase), 16'd3);
        steps(1, 14'h0063);

        $display("[TB] SLEEP");
        check("sleep_operand", 16'(operand), 16'h063);
        check("sleep_opcode",  16'(opcode),  16'd0);
        steps(4, 14'h3055);
`ifdef DECODER_SLEEP_EN
        steps(10, 14'h3055);
        check("park_phase", 16'(phase), 16'd0);
        check("park_fetch", 16'(fetch), 16'd0);
        applyStimulus(1'b0, 14'h3055, 1'b0, 1'b1);
        check("wake_phase", 16'(phase), 16'd1);
`else
        check("nopark_phase", 16'(phase), 16'd0);
        steps(1, 14'h3055);
        check("nopark_advance", 16'(phase), 16'd1);
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 99) < 15, 14'($urandom),
                              $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
